gemm_ctrl: RTL and testbench
============================

GEMM_CTRL -- requirements
Module: gemm_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state rising-edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port cpu_en, input, 1, MMIO select for this block from the EX/MEM stage.
REQ-004 SHALL have port cpu_we, input, 1, 1 = write, 0 = read.
REQ-005 SHALL have port cpu_addr, input, 3, word offset of the register.
REQ-006 SHALL have port cpu_wdata, input, 32, write data.
REQ-007 SHALL have port cpu_rdata, output, 32, read data.
REQ-008 SHALL have port wait_for_gemm, output, 1, pipeline stall request to hazard logic.
REQ-009 SHALL have ports gemm_a_addr, gemm_b_addr, gemm_c_addr, output, 32 each, operand base addresses.
REQ-010 SHALL have port gemm_dims, output, 24, {K[23:16], N[15:8], M[7:0]}.
REQ-011 SHALL have port gemm_start, output, 1, launch request.
REQ-012 SHALL have port gemm_ready, input, 1, accelerator accepts launch.
REQ-013 SHALL have port gemm_done, input, 1, one-cycle completion pulse.
REQ-014 SHALL have port irq, output, 1, level interrupt = done & irq_en.

Function
REQ-015 SHALL decode registers: 0 CTRL {bit1 irq_en, bit0 start (write-only, reads 0)}; 1 STATUS {bit2 err, bit1 done, bit0 busy}, with done/err write-1-to-clear; 2 A_ADDR; 3 B_ADDR; 4 C_ADDR; 5 DIMS[23:0]; 6 PERF (read-only busy-cycle count); 7 reads 0, write ignored.
REQ-016 SHALL return cpu_rdata combinationally from cpu_addr whenever cpu_en=1 and cpu_we=0, else 0.
REQ-017 SHALL run an FSM with states IDLE, ISSUE, BUSY.
REQ-018 IDLE: a write to CTRL with start=1 and M, N and K all nonzero SHALL copy A/B/C/DIMS into shadow registers, clear PERF, clear done, and enter ISSUE next cycle.
REQ-019 Start with any dimension 0 SHALL stay IDLE and set done=1 and err=1 next cycle, with no gemm_start.
REQ-020 ISSUE: gemm_start SHALL be 1 and held until the cycle gemm_ready=1, then the FSM SHALL enter BUSY.
REQ-021 BUSY: PERF SHALL increment each cycle, saturating at 0xFFFFFFFF; gemm_done=1 SHALL set done and return the FSM to IDLE.
REQ-022 gemm_done outside BUSY SHALL be ignored.
REQ-023 gemm_*_addr and gemm_dims SHALL be driven from the shadow registers only, stable from launch until the next launch.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 wait_for_gemm SHALL be combinationally 1 while cpu_en=1, cpu_we=1, cpu_addr is in {0,2,3,4,5}, and busy=1; the stalled write SHALL have no effect until it is re-presented after IDLE.
REQ-026 STATUS/PERF reads and STATUS W1C writes SHALL never stall.
REQ-027 If a done set and a W1C clear of done occur in the same cycle, done SHALL remain 1.
REQ-028 A CTRL write SHALL update irq_en in the same cycle as start.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, gemm_start=0, and irq_en, done, err, PERF, and all config and shadow registers to 0.
REQ-030 Reset mid-ISSUE/BUSY SHALL abandon the operation with no done set; a gemm_done arriving after reset SHALL be ignored.

Structure
REQ-031 The state enum, register offsets, and STATUS bit positions SHALL live in shared package gemm_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the PERF counter stays inline.

Verification
REQ-033 Write A=0x100, B=0x200, C=0x300, DIMS=0x040404, CTRL=0x3; hold gemm_ready=0 for 3 cycles -> gemm_start high 4 cycles, then BUSY; gemm_done after 10 BUSY cycles -> done=1, irq=1, PERF=10.
REQ-034 Start with DIMS=0x040004 -> no gemm_start, STATUS reads 0x6 next cycle.
REQ-035 Write A_ADDR during BUSY -> wait_for_gemm=1 each cycle until IDLE, then the write lands; gemm_a_addr unchanged until the next launch.
REQ-036 W1C STATUS=0x2 in the same cycle as gemm_done -> done stays 1.
REQ-037 Deassert rst_n during BUSY, then pulse gemm_done -> state IDLE, gemm_start=0, done=0, all registers 0.
REQ-038 Poll STATUS during BUSY -> rdata=0x1, wait_for_gemm=0.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared definitions for the GEMM accelerator control block.
//   - state_t        : controller FSM states
//   - REG_*          : MMIO word offsets decoded from cpu_addr
//   - CTRL_* / STAT_*: bit positions inside the CTRL and STATUS registers
package gemm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_A_ADDR = 3'd2;
    localparam logic [2:0] REG_B_ADDR = 3'd3;
    localparam logic [2:0] REG_C_ADDR = 3'd4;
    localparam logic [2:0] REG_DIMS   = 3'd5;
    localparam logic [2:0] REG_PERF   = 3'd6;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

endpackage

// File: rtl/gemm_ctrl.sv
// gemm_ctrl: MMIO register block and launch sequencer for a GEMM accelerator.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   cpu_en/we/addr/wdata/rdata  : CPU MMIO access (rdata is combinational)
//   wait_for_gemm               : stall request for config writes while busy
//   gemm_a/b/c_addr, gemm_dims  : operand descriptors from shadow registers
//   gemm_start / gemm_ready     : launch handshake
//   gemm_done                   : one-cycle completion pulse
//   irq                         : level interrupt, done & irq_en
module gemm_ctrl
    import gemm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_en,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        wait_for_gemm,
    output logic [31:0] gemm_a_addr,
    output logic [31:0] gemm_b_addr,
    output logic [31:0] gemm_c_addr,
    output logic [23:0] gemm_dims,
    output logic        gemm_start,
    input  logic        gemm_ready,
    input  logic        gemm_done,
    output logic        irq
);

    state_t      state_q, state_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [23:0] dims_q, dims_d;
    logic [31:0] perf_q, perf_d;
    logic [31:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_c_q, sh_c_d;
    logic [23:0] sh_dims_q, sh_dims_d;

    logic busy;
    logic cfg_access;
    logic wr_ok;
    logic start_req;
    logic dims_ok;

    always_comb begin
        state_d   = state_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        err_d     = err_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        dims_d    = dims_q;
        perf_d    = perf_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        sh_c_d    = sh_c_q;
        sh_dims_d = sh_dims_q;

        busy = (state_q != ST_IDLE);

        // Writes that could disturb an in-flight launch are held off while busy;
        // STATUS W1C and reads always proceed.
        cfg_access = cpu_en && cpu_we &&
                     (cpu_addr == REG_CTRL   || cpu_addr == REG_A_ADDR ||
                      cpu_addr == REG_B_ADDR || cpu_addr == REG_C_ADDR ||
                      cpu_addr == REG_DIMS);
        wait_for_gemm = cfg_access && busy;
        wr_ok         = cpu_en && cpu_we && !wait_for_gemm;
        start_req     = wr_ok && (cpu_addr == REG_CTRL) && cpu_wdata[CTRL_START];
        dims_ok       = (dims_q[7:0] != 8'd0) && (dims_q[15:8] != 8'd0) &&
                        (dims_q[23:16] != 8'd0);

        if (wr_ok) begin
            case (cpu_addr)
                REG_CTRL:   irq_en_d = cpu_wdata[CTRL_IRQ_EN];
                REG_STATUS: begin
                    if (cpu_wdata[STAT_DONE]) done_d = 1'b0;
                    if (cpu_wdata[STAT_ERR])  err_d  = 1'b0;
                end
                REG_A_ADDR: a_d    = cpu_wdata;
                REG_B_ADDR: b_d    = cpu_wdata;
                REG_C_ADDR: c_d    = cpu_wdata;
                REG_DIMS:   dims_d = cpu_wdata[23:0];
                default:    ;
            endcase
        end

        // FSM updates come after the register writes so a done set wins over
        // a same-cycle W1C clear.
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (dims_ok) begin
                        sh_a_d    = a_q;
                        sh_b_d    = b_q;
                        sh_c_d    = c_q;
                        sh_dims_d = dims_q;
                        perf_d    = 32'd0;
                        done_d    = 1'b0;
                        state_d   = ST_ISSUE;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (gemm_ready) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
                if (gemm_done) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            dims_q    <= '0;
            perf_q    <= '0;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            sh_c_q    <= '0;
            sh_dims_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            dims_q    <= dims_d;
            perf_q    <= perf_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            sh_c_q    <= sh_c_d;
            sh_dims_q <= sh_dims_d;
        end
    end

    always_comb begin
        cpu_rdata = 32'd0;
        if (cpu_en && !cpu_we) begin
            case (cpu_addr)
                REG_STATUS: cpu_rdata = {29'd0, err_q, done_q, busy};
                REG_A_ADDR: cpu_rdata = a_q;
                REG_B_ADDR: cpu_rdata = b_q;
                REG_C_ADDR: cpu_rdata = c_q;
                REG_DIMS:   cpu_rdata = {8'd0, dims_q};
                REG_PERF:   cpu_rdata = perf_q;
                default:    cpu_rdata = 32'd0;
            endcase
        end
    end

    assign gemm_start  = (state_q == ST_ISSUE);
    assign gemm_a_addr = sh_a_q;
    assign gemm_b_addr = sh_b_q;
    assign gemm_c_addr = sh_c_q;
    assign gemm_dims   = sh_dims_q;
    assign irq         = done_q && irq_en_q;

endmodule

// File: tb/tb_gemm_ctrl.sv
// tb_gemm_ctrl: self-checking bench for gemm_ctrl. A transaction-level model
// of the register file and launch sequence predicts every output each cycle;
// directed sequences add literal expectations on top.
module tb_gemm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_en, cpu_we;
    logic [2:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        wait_for_gemm;
    logic [31:0] gemm_a_addr, gemm_b_addr, gemm_c_addr;
    logic [23:0] gemm_dims;
    logic        gemm_start;
    logic        gemm_ready;
    logic        gemm_done;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gemm_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_en       (cpu_en),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .wait_for_gemm(wait_for_gemm),
        .gemm_a_addr  (gemm_a_addr),
        .gemm_b_addr  (gemm_b_addr),
        .gemm_c_addr  (gemm_c_addr),
        .gemm_dims    (gemm_dims),
        .gemm_start   (gemm_start),
        .gemm_ready   (gemm_ready),
        .gemm_done    (gemm_done),
        .irq          (irq)
    );

    // Model: phase 0 = idle, 1 = waiting for ready, 2 = accelerator running.
    int          m_phase;
    logic        m_irq_en, m_done, m_err;
    logic [31:0] m_a, m_b, m_c, m_perf;
    logic [23:0] m_dims;
    logic [31:0] m_sh_a, m_sh_b, m_sh_c;
    logic [23:0] m_sh_dims;

    task automatic model_reset();
        m_phase = 0; m_irq_en = 0; m_done = 0; m_err = 0;
        m_a = 0; m_b = 0; m_c = 0; m_dims = 0; m_perf = 0;
        m_sh_a = 0; m_sh_b = 0; m_sh_c = 0; m_sh_dims = 0;
    endtask

    function automatic logic m_stall();
        return cpu_en && cpu_we && (cpu_addr inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd5})
               && (m_phase != 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd1:    return {29'd0, m_err, m_done, (m_phase != 0)};
            3'd2:    return m_a;
            3'd3:    return m_b;
            3'd4:    return m_c;
            3'd5:    return {8'd0, m_dims};
            3'd6:    return m_perf;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        logic wr;
        int ph_n;
        logic irq_en_n, done_n, err_n;
        logic [31:0] a_n, b_n, c_n, perf_n;
        logic [23:0] dims_n;
        if (rst_n) begin
            wr = cpu_en && cpu_we && !m_stall();
            ph_n = m_phase; irq_en_n = m_irq_en; done_n = m_done; err_n = m_err;
            a_n = m_a; b_n = m_b; c_n = m_c; dims_n = m_dims; perf_n = m_perf;
            if (wr) begin
                case (cpu_addr)
                    3'd0: irq_en_n = cpu_wdata[1];
                    3'd1: begin
                        if (cpu_wdata[1]) done_n = 0;
                        if (cpu_wdata[2]) err_n = 0;
                    end
                    3'd2: a_n = cpu_wdata;
                    3'd3: b_n = cpu_wdata;
                    3'd4: c_n = cpu_wdata;
                    3'd5: dims_n = cpu_wdata[23:0];
                    default: ;
                endcase
            end
            if (m_phase == 0 && wr && cpu_addr == 3'd0 && cpu_wdata[0]) begin
                if (m_dims[7:0] != 0 && m_dims[15:8] != 0 && m_dims[23:16] != 0) begin
                    m_sh_a = m_a; m_sh_b = m_b; m_sh_c = m_c; m_sh_dims = m_dims;
                    perf_n = 0; done_n = 0; ph_n = 1;
                end else begin
                    done_n = 1; err_n = 1;
                end
            end else if (m_phase == 1) begin
                if (gemm_ready) ph_n = 2;
            end else if (m_phase == 2) begin
                perf_n = (m_perf == 32'hFFFF_FFFF) ? m_perf : m_perf + 1;
                if (gemm_done) begin
                    done_n = 1; ph_n = 0;
                end
            end
            m_phase = ph_n; m_irq_en = irq_en_n; m_done = done_n; m_err = err_n;
            m_a = a_n; m_b = b_n; m_c = c_n; m_dims = dims_n; m_perf = perf_n;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rdata", cpu_rdata, (cpu_en && !cpu_we) ? m_read(cpu_addr) : 32'd0);
        chk("wait_for_gemm", {31'd0, wait_for_gemm}, {31'd0, m_stall()});
        chk("gemm_start", {31'd0, gemm_start}, {31'd0, (m_phase == 1)});
        chk("gemm_a_addr", gemm_a_addr, m_sh_a);
        chk("gemm_b_addr", gemm_b_addr, m_sh_b);
        chk("gemm_c_addr", gemm_c_addr, m_sh_c);
        chk("gemm_dims", {8'd0, gemm_dims}, {8'd0, m_sh_dims});
        chk("irq", {31'd0, irq}, {31'd0, (m_done && m_irq_en)});
    endtask

    // Called at a falling edge: apply inputs, then compare 1 time unit later.
    task automatic drive(input logic en, input logic we, input logic [2:0] addr,
                         input logic [31:0] wd, input logic rdy, input logic gd);
        cpu_en = en; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        gemm_ready = rdy; gemm_done = gd;
        #1;
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
        drive(1, 1, addr, wd, 0, 0);
        tick();
    endtask

    task automatic apply_reset();
        drive(0, 0, 3'd0, 32'd0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("reset_gemm_start", {31'd0, gemm_start}, 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_en = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        gemm_ready = 0; gemm_done = 0;
        model_reset();
        @(negedge clk);
        drive(1, 0, 3'd1, 32'd0, 0, 0);
        chk("reset_status", cpu_rdata, 32'd0);
        tick();
        rst_n = 1'b1;

        // Launch with 3 cycles of back-pressure, then 10 busy cycles.
        wr(3'd2, 32'h100);
        wr(3'd3, 32'h200);
        wr(3'd4, 32'h300);
        wr(3'd5, 32'h040404);
        wr(3'd0, 32'h3);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 3'd0, 32'd0, (i == 3), 0);
            chk("issue_start_held", {31'd0, gemm_start}, 32'd1);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 3'd1, 32'd0, 0, (i == 9));
            chk("busy_status_poll", cpu_rdata, 32'h1);
            chk("busy_poll_nostall", {31'd0, wait_for_gemm}, 32'd0);
            tick();
        end
        drive(1, 0, 3'd1, 32'd0, 0, 0);
        chk("done_status", cpu_rdata, 32'h2);
        chk("done_irq", {31'd0, irq}, 32'd1);
        tick();
        drive(1, 0, 3'd6, 32'd0, 0, 0);
        chk("perf_count", cpu_rdata, 32'd10);
        chk("launch_a_addr", gemm_a_addr, 32'h100);
        chk("launch_dims", {8'd0, gemm_dims}, 32'h040404);
        tick();

        // Config write during a run stalls, then lands once idle.
        wr(3'd0, 32'h1);
        drive(1, 1, 3'd2, 32'h555, 1, 0);
        chk("stall_in_issue", {31'd0, wait_for_gemm}, 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 3'd2, 32'h555, 0, (i == 2));
            chk("stall_in_busy", {31'd0, wait_for_gemm}, 32'd1);
            tick();
        end
        drive(1, 1, 3'd2, 32'h555, 0, 0);
        chk("stall_released", {31'd0, wait_for_gemm}, 32'd0);
        tick();
        drive(1, 0, 3'd2, 32'd0, 0, 0);
        chk("stalled_write_landed", cpu_rdata, 32'h555);
        chk("shadow_a_unchanged", gemm_a_addr, 32'h100);
        tick();

        // W1C of done in the same cycle as gemm_done: done must survive.
        wr(3'd0, 32'h1);
        drive(0, 0, 3'd0, 32'd0, 1, 0);
        tick();
        drive(1, 0, 3'd1, 32'd0, 0, 0);
        chk("launch_clears_done", cpu_rdata, 32'h1);
        tick();
        drive(1, 1, 3'd1, 32'h2, 0, 1);
        tick();
        drive(1, 0, 3'd1, 32'd0, 0, 0);
        chk("done_set_beats_w1c", cpu_rdata, 32'h2);
        tick();

        // Zero dimension: error completion, no launch.
        wr(3'd5, 32'h040004);
        wr(3'd0, 32'h1);
        drive(1, 0, 3'd1, 32'd0, 0, 0);
        chk("zero_dim_status", cpu_rdata, 32'h6);
        chk("zero_dim_no_start", {31'd0, gemm_start}, 32'd0);
        tick();
        wr(3'd1, 32'h6);
        drive(1, 0, 3'd1, 32'd0, 0, 0);
        chk("w1c_clears_both", cpu_rdata, 32'h0);
        tick();

        // Reset in the middle of a run; late gemm_done is ignored.
        wr(3'd5, 32'h010101);
        wr(3'd0, 32'h3);
        drive(0, 0, 3'd0, 32'd0, 1, 0);
        tick();
        drive(0, 0, 3'd0, 32'd0, 0, 0);
        tick();
        apply_reset();
        drive(1, 0, 3'd1, 32'd0, 0, 1);
        chk("post_reset_status", cpu_rdata, 32'h0);
        tick();
        drive(1, 0, 3'd1, 32'd0, 0, 0);
        chk("late_done_ignored", cpu_rdata, 32'h0);
        tick();
        drive(1, 0, 3'd5, 32'd0, 0, 0);
        chk("post_reset_dims", cpu_rdata, 32'h0);
        chk("post_reset_shadow_a", gemm_a_addr, 32'h0);
        tick();

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic en, we, rdy, gd;
            logic [2:0] addr;
            logic [31:0] wd;
            if ($urandom_range(0, 599) == 0) begin
                apply_reset();
            end else begin
                en   = ($urandom_range(0, 3) != 0);
                we   = $urandom_range(0, 1) == 1;
                addr = 3'($urandom_range(0, 7));
                rdy  = ($urandom_range(0, 2) == 0);
                gd   = ($urandom_range(0, 7) == 0);
                case (addr)
                    3'd0: wd = 32'($urandom_range(0, 3));
                    3'd1: wd = 32'($urandom_range(0, 7));
                    3'd5: begin
                        wd = 32'd0;
                        for (int b = 0; b < 3; b++) begin
                            logic [7:0] byt;
                            byt = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                            wd[b*8 +: 8] = byt;
                        end
                        wd[31:24] = 8'($urandom);
                    end
                    default: wd = $urandom;
                endcase
                drive(en, we, addr, wd, rdy, gd);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
